fetch_stage: RTL and testbench

Instruction-fetch stage: owns the PC and the IF/ID pipeline register, and is the consumer of the hazard unit's stall outputs and the EX-stage branch flush. It fetches from a variable-latency instruction memory over a request/response handshake with one outstanding request. It holds the PC and IF/ID contents on load-use stalls, inserts bubbles when no instruction is ready, and discards in-flight or buffered instructions on a taken branch.

---
 rtl/imem_if.sv | 11 +
 rtl/fetch_stage.sv | 139 +++++++++++++
 tb/tb_fetch_stage.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_if.sv
// Instruction-memory request/response channel. One request may be outstanding at a time.
interface imem_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic        valid;
  logic [31:0] rdata;

  modport master (output req, output addr, input ready, input valid, input rdata);
  modport slave  (input req, input addr, output ready, output valid, output rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC and IF/ID register, fetches over a
// variable-latency imem handshake, honours hazard-unit stalls and branch flushes.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWrite,
  input  logic        IF_ID_Write,
  input  logic        Flush,
  input  logic [31:0] Branch_Target,
  imem_if.master      imem,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_RST = RESET_PC & ~XLEN'(3);

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] buf_q, buf_d;
  logic            load;
  logic [XLEN-1:0] load_instr;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] pc_plus4;
  logic            advance;

  assign advance   = PCWrite & IF_ID_Write;
  assign target    = Branch_Target & ~XLEN'(3);
  assign pc_plus4  = PC + XLEN'(4);
  assign imem.req  = (state_q == REQ);
  assign imem.addr = PC;

  // Next-state, PC redirect/advance and fetch-buffer capture; Flush wins everywhere.
  always_comb begin
    state_d    = state_q;
    pc_d       = PC;
    buf_d      = buf_q;
    load       = 1'b0;
    load_instr = buf_q;
    case (state_q)
      BOOT: begin
        if (Flush) pc_d = target;
        state_d = REQ;
      end
      REQ: begin
        if (Flush) begin
          pc_d    = target;
          // An accepted request to the old PC must have its response drained.
          state_d = imem.ready ? DROP : REQ;
        end else if (imem.ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (Flush) begin
          pc_d    = target;
          state_d = imem.valid ? REQ : DROP;
        end else if (imem.valid) begin
          if (advance) begin
            load       = 1'b1;
            load_instr = imem.rdata;
            pc_d       = pc_plus4;
            state_d    = REQ;
          end else begin
            buf_d   = imem.rdata;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (Flush) begin
          pc_d    = target;
          state_d = REQ;
        end else if (advance) begin
          load       = 1'b1;
          load_instr = buf_q;
          pc_d       = pc_plus4;
          state_d    = REQ;
        end
      end
      DROP: begin
        if (Flush) pc_d = target;
        // The stale response is the only thing that releases DROP.
        if (imem.valid) state_d = REQ;
      end
      default: state_d = BOOT;
    endcase
  end

  // State, PC and fetch-buffer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
      PC      <= PC_RST;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      PC      <= pc_d;
      buf_q   <= buf_d;
    end
  end

  // IF/ID pipeline register: flush, hold, load, else bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      IF_ID_Instr <= '0;
      IF_ID_PC4   <= '0;
      IF_ID_Valid <= 1'b0;
    end else if (Flush) begin
      IF_ID_Instr <= '0;
      IF_ID_PC4   <= '0;
      IF_ID_Valid <= 1'b0;
    end else if (!IF_ID_Write) begin
      IF_ID_Instr <= IF_ID_Instr;
      IF_ID_PC4   <= IF_ID_PC4;
      IF_ID_Valid <= IF_ID_Valid;
    end else if (load) begin
      IF_ID_Instr <= load_instr;
      IF_ID_PC4   <= pc_plus4;
      IF_ID_Valid <= 1'b1;
    end else begin
      IF_ID_Instr <= '0;
      IF_ID_Valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a latency-programmable instruction memory model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        PCWrite;
  logic        IF_ID_Write;
  logic        Flush;
  logic [31:0] Branch_Target;
  logic [31:0] PC;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_Valid;

  imem_if imem();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PCWrite      (PCWrite),
    .IF_ID_Write  (IF_ID_Write),
    .Flush        (Flush),
    .Branch_Target(Branch_Target),
    .imem         (imem),
    .PC           (PC),
    .IF_ID_Instr  (IF_ID_Instr),
    .IF_ID_PC4    (IF_ID_PC4),
    .IF_ID_Valid  (IF_ID_Valid)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  int          lat = 1;
  int          rem = 0;
  logic [31:0] pend = '0;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr = '0;

  // Compare and count; one FAIL line per mismatch.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: sample acceptance, then drive this cycle's memory response.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = imem.req & imem.ready;
    a   = imem.addr;
    @(posedge clk);
    #1;
    imem.valid = 1'b0;
    if (acc) begin
      rem  = lat;
      pend = a;
    end
    if (rem > 0) begin
      rem--;
      if (rem == 0) begin
        imem.valid = 1'b1;
        imem.rdata = ovr_en ? ovr : (pend ^ 32'h1300_0000);
      end
    end
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    PCWrite       = 1'b1;
    IF_ID_Write   = 1'b1;
    Flush         = 1'b0;
    Branch_Target = '0;
    imem.ready    = 1'b1;
    imem.valid    = 1'b0;
    imem.rdata    = '0;
    rem           = 0;
    ovr_en        = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state and 1-cycle-latency streaming.
    lat = 1;
    do_reset();
    check("rst_pc", PC, 32'h0);
    check("rst_addr", imem.addr, 32'h0);
    check("rst_req", 32'(imem.req), 32'h0);
    check("rst_valid", 32'(IF_ID_Valid), 32'h0);
    check("rst_instr", IF_ID_Instr, 32'h0);
    check("rst_pc4", IF_ID_PC4, 32'h0);
    tick();
    check("s_req0", 32'(imem.req), 32'h1);
    check("s_addr0", imem.addr, 32'h0);
    tick();
    check("s_wait_req", 32'(imem.req), 32'h0);
    check("s_wait_valid", 32'(IF_ID_Valid), 32'h0);
    tick();
    check("s_valid1", 32'(IF_ID_Valid), 32'h1);
    check("s_pc4_1", IF_ID_PC4, 32'h4);
    check("s_instr1", IF_ID_Instr, 32'h1300_0000);
    check("s_addr1", imem.addr, 32'h4);
    tick();
    check("s_bubble", 32'(IF_ID_Valid), 32'h0);
    tick();
    check("s_valid2", 32'(IF_ID_Valid), 32'h1);
    check("s_pc4_2", IF_ID_PC4, 32'h8);
    check("s_addr2", imem.addr, 32'h8);

    // Load-use stall while the response arrives.
    ovr_en = 1'b1;
    ovr    = 32'h8C02_0000;
    tick();
    PCWrite     = 1'b0;
    IF_ID_Write = 1'b0;
    tick();
    check("st_hold_valid", 32'(IF_ID_Valid), 32'h0);
    check("st_hold_pc", PC, 32'h8);
    check("st_hold_req", 32'(imem.req), 32'h0);
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    ovr_en      = 1'b0;
    tick();
    check("st_instr", IF_ID_Instr, 32'h8C02_0000);
    check("st_valid", 32'(IF_ID_Valid), 32'h1);
    check("st_pc4", IF_ID_PC4, 32'hC);
    check("st_pc", PC, 32'hC);
    tick();
    check("st_nodup", 32'(IF_ID_Valid), 32'h0);
    tick();
    check("st_next_instr", IF_ID_Instr, 32'h1300_000C);
    check("st_next_pc4", IF_ID_PC4, 32'h10);

    // Flush in WAIT with latency 3: stale response drained in DROP.
    lat = 3;
    do_reset();
    tick();
    tick();
    Flush         = 1'b1;
    Branch_Target = 32'h0000_0103;
    tick();
    Flush = 1'b0;
    check("fw_req", 32'(imem.req), 32'h0);
    check("fw_pc", PC, 32'h100);
    check("fw_valid", 32'(IF_ID_Valid), 32'h0);
    tick();
    tick();
    check("fw_req2", 32'(imem.req), 32'h1);
    check("fw_addr", imem.addr, 32'h100);
    tick();
    tick();
    tick();
    check("fw_gap", 32'(IF_ID_Valid), 32'h0);
    tick();
    check("fw_valid2", 32'(IF_ID_Valid), 32'h1);
    check("fw_pc4", IF_ID_PC4, 32'h104);
    check("fw_instr", IF_ID_Instr, 32'h1300_0100);

    // Flush coinciding with the response: no DROP.
    lat = 1;
    do_reset();
    tick();
    tick();
    Flush         = 1'b1;
    Branch_Target = 32'h0000_0200;
    tick();
    Flush = 1'b0;
    check("fv_req", 32'(imem.req), 32'h1);
    check("fv_addr", imem.addr, 32'h200);
    check("fv_valid", 32'(IF_ID_Valid), 32'h0);
    tick();
    tick();
    check("fv_pc4", IF_ID_PC4, 32'h204);
    check("fv_instr", IF_ID_Instr, 32'h1300_0200);

    // Flush and stall together in HOLD.
    do_reset();
    tick();
    tick();
    PCWrite     = 1'b0;
    IF_ID_Write = 1'b0;
    tick();
    check("fh_hold_req", 32'(imem.req), 32'h0);
    Flush         = 1'b1;
    Branch_Target = 32'h0000_0300;
    tick();
    Flush       = 1'b0;
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    check("fh_req", 32'(imem.req), 32'h1);
    check("fh_addr", imem.addr, 32'h300);
    check("fh_valid", 32'(IF_ID_Valid), 32'h0);
    tick();
    tick();
    check("fh_instr", IF_ID_Instr, 32'h1300_0300);
    check("fh_pc4", IF_ID_PC4, 32'h304);

    // Redirect while not ready, then PC+4 wrap at the top of memory.
    do_reset();
    tick();
    imem.ready    = 1'b0;
    Flush         = 1'b1;
    Branch_Target = 32'hFFFF_FFFC;
    tick();
    imem.ready = 1'b1;
    Flush      = 1'b0;
    check("wr_req", 32'(imem.req), 32'h1);
    check("wr_addr", imem.addr, 32'hFFFF_FFFC);
    tick();
    tick();
    check("wr_valid", 32'(IF_ID_Valid), 32'h1);
    check("wr_pc4", IF_ID_PC4, 32'h0);
    check("wr_instr", IF_ID_Instr, 32'hECFF_FFFC);
    check("wr_pc", PC, 32'h0);

    // Asynchronous reset pulse mid-WAIT with a live IF/ID entry.
    lat         = 3;
    PCWrite     = 1'b0;
    IF_ID_Write = 1'b0;
    tick();
    check("ar_pre_valid", 32'(IF_ID_Valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(IF_ID_Valid), 32'h0);
    check("ar_instr", IF_ID_Instr, 32'h0);
    check("ar_pc4", IF_ID_PC4, 32'h0);
    check("ar_pc", PC, 32'h0);
    check("ar_req", 32'(imem.req), 32'h0);
    check("ar_addr", imem.addr, 32'h0);
    #1;
    rem         = 0;
    imem.valid  = 1'b0;
    PCWrite     = 1'b1;
    IF_ID_Write = 1'b1;
    rst_n       = 1'b1;
    tick();
    check("ar_boot_req", 32'(imem.req), 32'h1);
    check("ar_boot_addr", imem.addr, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
